serial_to_parallel_rx: RTL and testbench
========================================

// Module: serial_to_parallel_rx
// PURPOSE
// - Serial-in / parallel-out receiver: collects a framed serial bit stream into a WIDTH-bit word.
// - Sits at the far end of the parallel-to-serial shift chain; rebuilds the word that the chain shifts out.
// - Presents the word with a valid/ack handshake; flags words lost while the previous word is unacknowledged.
// PARAMETERS
// - WIDTH  default 5  data bits per frame (>=2)
// PORTS
// - clk      in   1      system clock; all state updates on posedge clk
// - clear    in   1      reset; synchronous, active-low (clear==0 at posedge clk resets)
// - sin      in   1      serial data line; idles at 0
// - bit_en   in   1      bit strobe; sin is sampled only on cycles with bit_en==1
// - ack      in   1      consumer accepts data while valid==1
// - data     out  WIDTH  received word; stable while valid==1
// - valid    out  1      word available; held until ack
// - busy     out  1      frame in progress (state SHIFT)
// - overrun  out  1      sticky: start bit seen while a word was unacknowledged
// BEHAVIOUR
// - Reset (clear==0 at posedge): state=IDLE; data=0, valid=0, busy=0, overrun=0; shift reg=0; bit count=0.
// - Reset has priority over every other input and aborts a frame in progress (partial bits discarded).
// - Frame: one start bit (sin==1), then WIDTH data bits; first data bit -> data[WIDTH-1], last -> data[0].
// - FSM, 2-bit state:
// - IDLE : bit_en&&sin -> SHIFT, count=0; bit_en&&!sin -> stay (line idle). busy=0.
// - SHIFT: busy=1. On bit_en: sreg={sreg[WIDTH-2:0],sin}, count++. Without bit_en: hold all.
// -   On the bit_en that samples the last data bit (count==WIDTH-1): data<={sreg[WIDTH-2:0],sin},
// -   valid<=1, state->HOLD. valid is visible the cycle after the last strobe (latency 1 clk).
// - HOLD : valid=1; data frozen. ack -> valid<=0, state->IDLE.
// -   bit_en&&sin without ack -> overrun<=1; that frame is dropped; the FSM stays in HOLD and ignores
// -   line traffic until ack.
// -   ack together with bit_en&&sin -> ack is honoured, that start bit is accepted: state->SHIFT, count=0,
// -   valid<=0, overrun unchanged.
// - ack outside HOLD is ignored. sin without bit_en is never sampled.
// - overrun clears only on reset. valid is set only by frame completion and cleared only by ack or reset.
// - Minimum frame time: WIDTH+1 strobes. Back-to-back frames need ack no later than the next start strobe.
// - Counter: $clog2(WIDTH) bits. It never exceeds WIDTH-1 and is reloaded to 0 on every start bit.
// STRUCTURE
// - Shared package: state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_HOLD=2'd2.
// - Sub-module shift_in_reg (WIDTH; clk, clear, en, d -> q[WIDTH-1:0]).
// -   Left-shift register with synchronous active-low clear.
// - Top module holds the FSM, bit counter, data/valid/overrun registers.
// TESTING (WIDTH=5, one bit_en per clk unless noted)
// - Reset: hold clear=0 3 clks with sin=1, bit_en=1, ack=1 -> data=0, valid=0, busy=0, overrun=0.
// - Single frame: sin=1,1,0,1,1,0 on 6 strobes -> busy=1 for strobes 2-6.
// -   valid=1 with data=5'b10110 one clk after strobe 6. ack one clk later -> valid=0, state IDLE.
// - Gapped strobes: same frame with bit_en=1 every 3rd clk only -> identical data=5'b10110.
// -   No state change on clks with bit_en=0.
// - Overrun: complete 5'b00001 and withhold ack, then send start+5'b11111 -> overrun=1.
// -   data stays 5'b00001. ack then sends 5'b01010 -> data=5'b01010, overrun still 1.
// - Ack+start same cycle: in HOLD with data=5'b11100, assert ack and sin=1,bit_en=1 together.
// -   Then send 5'b00111 -> data=5'b00111, overrun=0.
// - Mid-frame reset: after start + 3 data bits drive clear=0 one clk, then send 5'b10001 -> data=5'b10001.
// -   No residue from the aborted frame.

Source files
------------

// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM state encoding.
package serial_to_parallel_rx_pkg;

    // 2-bit state encoding; S_IDLE waits for a start bit, S_SHIFT collects
    // data bits, S_HOLD presents the finished word until it is acknowledged.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage : serial_to_parallel_rx_pkg

// File: rtl/serial_to_parallel_rx_shift_in_reg.sv
// Left-shift register: new bits enter at q[0] and move towards q[WIDTH-1].
module shift_in_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // Shift one bit in on every enabled cycle; clear==0 empties the register.
    always_ff @(posedge clk) begin
        // NOTE: registers are always written with <= so every flop samples
        // the pre-edge values of its neighbours, exactly like the hardware.
        if (!clear) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], d};
        end
    end

endmodule : shift_in_reg

// File: rtl/serial_to_parallel_rx.sv
// Serial-in / parallel-out receiver. A frame is one start bit (sin==1)
// followed by WIDTH data bits, MSB first, each sampled on a bit_en strobe.
// The finished word is held with valid until ack; a start bit arriving while
// a word is still unacknowledged sets the sticky overrun flag.
module serial_to_parallel_rx
    import serial_to_parallel_rx_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   word_nxt;
    logic               start_seen;
    logic               shift_en;
    logic               start_frame;
    logic               load_word;
    logic               clr_valid;
    logic               set_overrun;

    assign start_seen = bit_en && sin;
    assign shift_en   = (state == S_SHIFT) && bit_en;

    // The word as it stands once the bit on sin has been shifted in; the
    // oldest register bit falls off the top.
    assign word_nxt = WIDTH'({sreg, sin});

    shift_in_reg #(
        .WIDTH (WIDTH)
    ) u_shift_in_reg (
        .clk   (clk),
        .clear (clear),
        .en    (shift_en),
        .d     (sin),
        .q     (sreg)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        start_frame = 1'b0;
        load_word   = 1'b0;
        clr_valid   = 1'b0;
        set_overrun = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_seen) begin
                    state_nxt   = S_SHIFT;
                    start_frame = 1'b1;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (bit_en && (count == LAST_BIT)) begin
                    state_nxt = S_HOLD;
                    load_word = 1'b1;
                end
            end
            S_HOLD: begin
                if (ack) begin
                    clr_valid = 1'b1;
                    // A start bit coinciding with ack begins the next frame.
                    if (start_seen) begin
                        state_nxt   = S_SHIFT;
                        start_frame = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (start_seen) begin
                    // Unacknowledged word: the new frame is lost.
                    set_overrun = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Data-bit counter: reloaded on each start bit, wraps after the last bit.
    always_ff @(posedge clk) begin
        if (!clear) begin
            count <= '0;
        end else if (start_frame) begin
            count <= '0;
        end else if (shift_en) begin
            count <= (count == LAST_BIT) ? '0 : count + 1'b1;
        end
    end

    // Output word and handshake: captured on the last data bit, released by ack.
    always_ff @(posedge clk) begin
        if (!clear) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load_word) begin
            data  <= word_nxt;
            valid <= 1'b1;
        end else if (clr_valid) begin
            valid <= 1'b0;
        end
    end

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!clear) begin
            overrun <= 1'b0;
        end else if (set_overrun) begin
            overrun <= 1'b1;
        end
    end

endmodule : serial_to_parallel_rx

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (WIDTH=5). Inputs change 1 ns
// after each rising edge and outputs are checked at that same point.
module tb_serial_to_parallel_rx;

    localparam int W = 5;

    logic         clk;
    logic         clear;
    logic         sin;
    logic         bit_en;
    logic         ack;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         overrun;

    int passed = 0;
    int total  = 0;

    serial_to_parallel_rx #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .sin     (sin),
        .bit_en  (bit_en),
        .ack     (ack),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit_en strobe carrying s, then gap clocks with bit_en low.
    task automatic strobe(input logic s, input int gap);
        sin    = s;
        bit_en = 1'b1;
        tick();
        sin    = 1'b0;
        bit_en = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int gap);
        strobe(1'b1, gap);
        for (int i = W - 1; i >= 0; i--) strobe(w[i], gap);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0; sin = 1'b1; bit_en = 1'b1; ack = 1'b1;
        repeat (3) tick();
        total++; if (data !== 5'b00000) $display("FAIL reset_data: got %b want 00000", data); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        clear = 1'b1; sin = 1'b0; bit_en = 1'b0; ack = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [W-1:0] w;
        w = 5'b10110;
        // sin high without a strobe must not start a frame.
        sin = 1'b1;
        repeat (2) tick();
        sin = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL unstrobed_sin_busy: got %b want 0", busy); else passed++;
        strobe(1'b1, 0);
        total++; if (busy !== 1'b1) $display("FAIL frame_busy_after_start: got %b want 1", busy); else passed++;
        for (int i = W - 1; i >= 1; i--) begin
            strobe(w[i], 0);
            total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL frame_mid_bit%0d: busy=%b valid=%b want busy=1 valid=0", i, busy, valid); else passed++;
        end
        strobe(w[0], 0);
        total++; if (valid !== 1'b1) $display("FAIL frame_valid: got %b want 1", valid); else passed++;
        total++; if (data !== 5'b10110) $display("FAIL frame_data: got %b want 10110", data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL frame_busy_hold: got %b want 0", busy); else passed++;
        tick();
        total++; if (valid !== 1'b1 || data !== 5'b10110) $display("FAIL frame_hold: valid=%b data=%b want 1 10110", valid, data); else passed++;
        do_ack();
        total++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL frame_ack: valid=%b busy=%b want 0 0", valid, busy); else passed++;
        // ack in IDLE has no effect.
        do_ack();
        total++; if (valid !== 1'b0 || busy !== 1'b0 || data !== 5'b10110) $display("FAIL idle_ack: valid=%b busy=%b data=%b want 0 0 10110", valid, busy, data); else passed++;
    endtask

    task automatic test_gapped();
        logic [W:0] bits;
        bits = 6'b110110;
        for (int j = W; j >= 0; j--) begin
            strobe(bits[j], 2);
            total++; if (busy !== (j != 0)) $display("FAIL gapped_busy_%0d: got %b want %b", j, busy, (j != 0)); else passed++;
        end
        total++; if (valid !== 1'b1 || data !== 5'b10110) $display("FAIL gapped_data: valid=%b data=%b want 1 10110", valid, data); else passed++;
        do_ack();
    endtask

    task automatic test_overrun();
        send_frame(5'b00001, 0);
        total++; if (valid !== 1'b1 || data !== 5'b00001 || overrun !== 1'b0) $display("FAIL ovr_first: valid=%b data=%b ovr=%b want 1 00001 0", valid, data, overrun); else passed++;
        send_frame(5'b11111, 0);
        total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
        total++; if (data !== 5'b00001 || valid !== 1'b1 || busy !== 1'b0) $display("FAIL ovr_hold: data=%b valid=%b busy=%b want 00001 1 0", data, valid, busy); else passed++;
        do_ack();
        total++; if (valid !== 1'b0) $display("FAIL ovr_ack: got %b want 0", valid); else passed++;
        send_frame(5'b01010, 0);
        total++; if (data !== 5'b01010 || valid !== 1'b1) $display("FAIL ovr_next_data: data=%b valid=%b want 01010 1", data, valid); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
        do_ack();
    endtask

    task automatic test_ack_start();
        logic [W-1:0] w;
        clear = 1'b0;
        tick();
        clear = 1'b1;
        send_frame(5'b11100, 0);
        total++; if (data !== 5'b11100 || valid !== 1'b1) $display("FAIL ackst_first: data=%b valid=%b want 11100 1", data, valid); else passed++;
        ack = 1'b1;
        strobe(1'b1, 0);
        ack = 1'b0;
        total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL ackst_start: busy=%b valid=%b want 1 0", busy, valid); else passed++;
        w = 5'b00111;
        for (int i = W - 1; i >= 0; i--) strobe(w[i], 0);
        total++; if (data !== 5'b00111 || valid !== 1'b1) $display("FAIL ackst_data: data=%b valid=%b want 00111 1", data, valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL ackst_overrun: got %b want 0", overrun); else passed++;
        do_ack();
    endtask

    task automatic test_mid_frame_reset();
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else passed++;
        clear = 1'b0;
        tick();
        clear = 1'b1;
        total++; if (busy !== 1'b0 || valid !== 1'b0 || data !== 5'b00000) $display("FAIL midrst_state: busy=%b valid=%b data=%b want 0 0 00000", busy, valid, data); else passed++;
        send_frame(5'b10001, 0);
        total++; if (data !== 5'b10001 || valid !== 1'b1 || overrun !== 1'b0) $display("FAIL midrst_data: data=%b valid=%b ovr=%b want 10001 1 0", data, valid, overrun); else passed++;
        do_ack();
    endtask

    initial begin
        clear = 1'b0; sin = 1'b0; bit_en = 1'b0; ack = 1'b0;
        test_reset();
        test_single_frame();
        test_gapped();
        test_overrun();
        test_ack_start();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_serial_to_parallel_rx
